// File: rtl/branch_target_pkg.sv
// -----------------------------------------------------------------------------
// branch_target_pkg
// Shared definitions for the branch-target / immediate generator pipe.
//   mode_e        : immediate field select and extension encodings
//   params_legal  : elaboration-time legality check of the pipe parameters
// -----------------------------------------------------------------------------
package branch_target_pkg;

  typedef enum logic [1:0] {
    MODE_SEXT_MIN = 2'b00,
    MODE_SEXT_MAX = 2'b01,
    MODE_ZEXT_MIN = 2'b10,
    MODE_ZEXT_MAX = 2'b11
  } mode_e;

  function automatic bit params_legal(input int unsigned min_w,
                                      input int unsigned max_w,
                                      input int unsigned out_w,
                                      input int unsigned sh_amt);
    return (min_w > 0) && (min_w < max_w) && (max_w < out_w) && (sh_amt <= 3);
  endfunction

endpackage

// File: rtl/branch_target_pipe_if.sv
// -----------------------------------------------------------------------------
// branch_target_pipe_if
// Request/response bundle of branch_target_pipe.
//   request : in_valid, in_ready, imm_in, mode, use_pc, pc_in, tag_in
//   response: out_valid, out_ready, result, tag_out, ovf
// Modports:
//   master : requester + consumer side (decode / operand muxes, testbench)
//   slave  : the pipe itself
// -----------------------------------------------------------------------------
interface branch_target_pipe_if #(
  parameter int unsigned DATA_IN_MAX_WIDTH = 12,
  parameter int unsigned DATA_OUT_WIDTH    = 16,
  parameter int unsigned TAG_WIDTH         = 4
);

  logic                         in_valid;
  logic                         in_ready;
  logic [DATA_IN_MAX_WIDTH-1:0] imm_in;
  logic [1:0]                   mode;
  logic                         use_pc;
  logic [DATA_OUT_WIDTH-1:0]    pc_in;
  logic [TAG_WIDTH-1:0]         tag_in;

  logic                         out_valid;
  logic                         out_ready;
  logic [DATA_OUT_WIDTH-1:0]    result;
  logic [TAG_WIDTH-1:0]         tag_out;
  logic                         ovf;

  modport master (
    output in_valid, imm_in, mode, use_pc, pc_in, tag_in, out_ready,
    input  in_ready, out_valid, result, tag_out, ovf
  );

  modport slave (
    input  in_valid, imm_in, mode, use_pc, pc_in, tag_in, out_ready,
    output in_ready, out_valid, result, tag_out, ovf
  );

endinterface

// File: rtl/branch_target_pipe_imm_ext_shift.sv
// -----------------------------------------------------------------------------
// imm_ext_shift
// Combinational field select, sign/zero extension and constant left shift.
//   imm_i     in  raw immediate (wide field; narrow field = low MIN bits)
//   mode_i    in  field select / extension kind
//   shifted_o out extended value shifted left by SHIFT_AMOUNT, zero fill
//   loss_o    out bits lost by the shift (only with BRANCH_TARGET_OVF_EN)
// -----------------------------------------------------------------------------
module imm_ext_shift
  import branch_target_pkg::*;
#(
  parameter int unsigned DATA_IN_MAX_WIDTH = 12,
  parameter int unsigned DATA_IN_MIN_WIDTH = 8,
  parameter int unsigned DATA_OUT_WIDTH    = 16,
  parameter int unsigned SHIFT_AMOUNT      = 1
) (
  input  logic [DATA_IN_MAX_WIDTH-1:0] imm_i,
  input  mode_e                        mode_i,
`ifdef BRANCH_TARGET_OVF_EN
  output logic                         loss_o,
`endif
  output logic [DATA_OUT_WIDTH-1:0]    shifted_o
);

  logic                         sext;
  logic [DATA_IN_MAX_WIDTH-1:0] field;
  logic [DATA_OUT_WIDTH-1:0]    ext;

  always_comb begin
    sext  = (mode_i == MODE_SEXT_MIN) || (mode_i == MODE_SEXT_MAX);
    field = imm_i;
    // Narrow field is first widened to the wide-field width so both paths
    // share a single final extension step.
    if ((mode_i == MODE_SEXT_MIN) || (mode_i == MODE_ZEXT_MIN)) begin
      field = {{(DATA_IN_MAX_WIDTH-DATA_IN_MIN_WIDTH){sext & imm_i[DATA_IN_MIN_WIDTH-1]}},
               imm_i[DATA_IN_MIN_WIDTH-1:0]};
    end
    ext       = {{(DATA_OUT_WIDTH-DATA_IN_MAX_WIDTH){sext & field[DATA_IN_MAX_WIDTH-1]}}, field};
    shifted_o = ext << SHIFT_AMOUNT;
  end

`ifdef BRANCH_TARGET_OVF_EN
  // Signed: a shifted-out bit differing from the new MSB changes the value.
  // Unsigned: any shifted-out one is lost.
  always_comb begin
    loss_o = 1'b0;
    for (int unsigned i = 0; i < SHIFT_AMOUNT; i++) begin
      if (sext ? (ext[DATA_OUT_WIDTH-1-i] != shifted_o[DATA_OUT_WIDTH-1])
               : ext[DATA_OUT_WIDTH-1-i]) begin
        loss_o = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/branch_target_pipe.sv
// -----------------------------------------------------------------------------
// branch_target_pipe
// Two-stage immediate / branch-target generator with valid/ready on both sides.
//   S1: select + extend + shift the immediate, capture pc/use_pc/tag.
//   S2: optional pc add, capture result/tag/ovf (drive the outputs).
// Ports:
//   clk  in  rising-edge clock
//   rst  in  synchronous reset, active-high
//   bus  slave modport of branch_target_pipe_if (request + response)
// Optional feature: define BRANCH_TARGET_OVF_EN to compute ovf from shift loss
// and address wrap; otherwise ovf is tied low.
// -----------------------------------------------------------------------------
module branch_target_pipe
  import branch_target_pkg::*;
#(
  parameter int unsigned DATA_IN_MAX_WIDTH = 12,
  parameter int unsigned DATA_IN_MIN_WIDTH = 8,
  parameter int unsigned DATA_OUT_WIDTH    = 16,
  parameter int unsigned SHIFT_AMOUNT      = 1,
  parameter int unsigned TAG_WIDTH         = 4
) (
  input logic                clk,
  input logic                rst,
  branch_target_pipe_if.slave bus
);

  if (!params_legal(DATA_IN_MIN_WIDTH, DATA_IN_MAX_WIDTH, DATA_OUT_WIDTH, SHIFT_AMOUNT)) begin : g_bad_params
    $error("branch_target_pipe: illegal parameter combination");
  end

  // Handshake chain
  logic s1_adv;
  logic s2_adv;

  // Stage 1 registers
  logic                      s1_valid_q;
  logic [DATA_OUT_WIDTH-1:0] s1_off_q;
  logic [DATA_OUT_WIDTH-1:0] s1_pc_q;
  logic                      s1_use_pc_q;
  logic [TAG_WIDTH-1:0]      s1_tag_q;

  // Stage 2 registers
  logic                      s2_valid_q;
  logic [DATA_OUT_WIDTH-1:0] result_q;
  logic [TAG_WIDTH-1:0]      tag_q;

  logic [DATA_OUT_WIDTH-1:0] off_d;
  logic [DATA_OUT_WIDTH-1:0] sum;
  logic [DATA_OUT_WIDTH-1:0] result_d;

`ifdef BRANCH_TARGET_OVF_EN
  logic loss_d;
  logic s1_loss_q;
  logic s1_sext_q;
  logic carry;
  logic wrap;
  logic ovf_d;
  logic ovf_q;
`endif

  assign s2_adv      = !s2_valid_q || bus.out_ready;
  assign s1_adv      = !s1_valid_q || s2_adv;
  assign bus.in_ready = s1_adv;

  imm_ext_shift #(
    .DATA_IN_MAX_WIDTH (DATA_IN_MAX_WIDTH),
    .DATA_IN_MIN_WIDTH (DATA_IN_MIN_WIDTH),
    .DATA_OUT_WIDTH    (DATA_OUT_WIDTH),
    .SHIFT_AMOUNT      (SHIFT_AMOUNT)
  ) u_imm_ext_shift (
    .imm_i     (bus.imm_in),
    .mode_i    (mode_e'(bus.mode)),
`ifdef BRANCH_TARGET_OVF_EN
    .loss_o    (loss_d),
`endif
    .shifted_o (off_d)
  );

  always_comb begin
`ifdef BRANCH_TARGET_OVF_EN
    {carry, sum} = {1'b0, s1_pc_q} + {1'b0, s1_off_q};
    // Signed offset: a negative offset stays in range only if the add carries,
    // a non-negative one only if it does not.
    wrap  = carry ^ (s1_sext_q & s1_off_q[DATA_OUT_WIDTH-1]);
    ovf_d = s1_loss_q | (s1_use_pc_q & wrap);
`else
    sum = s1_pc_q + s1_off_q;
`endif
    result_d = s1_use_pc_q ? sum : s1_off_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_off_q    <= '0;
      s1_pc_q     <= '0;
      s1_use_pc_q <= 1'b0;
      s1_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
      result_q    <= '0;
      tag_q       <= '0;
`ifdef BRANCH_TARGET_OVF_EN
      s1_loss_q   <= 1'b0;
      s1_sext_q   <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      if (s1_adv) begin
        s1_valid_q <= bus.in_valid;
        if (bus.in_valid) begin
          s1_off_q    <= off_d;
          s1_pc_q     <= bus.pc_in;
          s1_use_pc_q <= bus.use_pc;
          s1_tag_q    <= bus.tag_in;
`ifdef BRANCH_TARGET_OVF_EN
          s1_loss_q   <= loss_d;
          s1_sext_q   <= ~bus.mode[1];
`endif
        end
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          result_q <= result_d;
          tag_q    <= s1_tag_q;
`ifdef BRANCH_TARGET_OVF_EN
          ovf_q    <= ovf_d;
`endif
        end
      end
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.result    = result_q;
  assign bus.tag_out   = tag_q;
`ifdef BRANCH_TARGET_OVF_EN
  assign bus.ovf       = ovf_q;
`else
  assign bus.ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_branch_target_pipe.sv
// -----------------------------------------------------------------------------
// tb_branch_target_pipe
// Scoreboard bench for branch_target_pipe: expected results are queued when a
// request is accepted and compared when the pipe hands a result over.
// ovf expectations follow BRANCH_TARGET_OVF_EN.
// -----------------------------------------------------------------------------
module tb_branch_target_pipe;

  localparam int unsigned MAXW = 12;
  localparam int unsigned MINW = 8;
  localparam int unsigned OUTW = 16;
  localparam int unsigned SH   = 1;
  localparam int unsigned TAGW = 4;

  typedef struct {
    logic [OUTW-1:0] result;
    logic [TAGW-1:0] tag;
    logic            ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   n_acc = 0;
  int   n_drn = 0;

  exp_t sb[$];
  exp_t golden_q[$];
  int   drain_cyc[$];

  logic            hold_pending = 1'b0;
  logic [OUTW-1:0] held_result;
  logic [TAGW-1:0] held_tag;
  logic            held_ovf;

  branch_target_pipe_if #(
    .DATA_IN_MAX_WIDTH (MAXW),
    .DATA_OUT_WIDTH    (OUTW),
    .TAG_WIDTH         (TAGW)
  ) bus ();

  branch_target_pipe #(
    .DATA_IN_MAX_WIDTH (MAXW),
    .DATA_IN_MIN_WIDTH (MINW),
    .DATA_OUT_WIDTH    (OUTW),
    .SHIFT_AMOUNT      (SH),
    .TAG_WIDTH         (TAGW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model in plain integer arithmetic.
  function automatic exp_t model(input logic [MAXW-1:0] imm, input logic [1:0] mode,
                                 input logic use_pc, input logic [OUTW-1:0] pc,
                                 input logic [TAGW-1:0] tag);
    exp_t        r;
    longint      v;
    longint      s;
    logic [MINW-1:0] f;
    bit          sext;
    bit          loss;
    bit          wrap;
    sext = !mode[1];
    f    = imm[MINW-1:0];
    if (mode[0]) v = sext ? longint'($signed(imm)) : longint'(imm);
    else         v = sext ? longint'($signed(f))   : longint'(f);
    v    = v * (longint'(1) << SH);
    loss = sext ? (v < -(longint'(1) << (OUTW-1)) || v >= (longint'(1) << (OUTW-1)))
                : (v >= (longint'(1) << OUTW));
    s    = longint'(pc) + v;
    wrap = use_pc && (s < 0 || s >= (longint'(1) << OUTW));
    r.result = use_pc ? s[OUTW-1:0] : v[OUTW-1:0];
    r.tag    = tag;
`ifdef BRANCH_TARGET_OVF_EN
    r.ovf    = loss | wrap;
`else
    r.ovf    = 1'b0;
`endif
    return r;
  endfunction

  // Monitor: sample mid-cycle, the values seen here are the ones the next
  // rising edge acts on.
  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        if (bus.out_valid) begin
          check("hold_result", bus.result, held_result);
          check("hold_tag", bus.tag_out, held_tag);
          check("hold_ovf", bus.ovf, held_ovf);
        end else begin
          check("hold_valid", bus.out_valid, 1);
        end
      end
      hold_pending = bus.out_valid && !bus.out_ready;
      held_result  = bus.result;
      held_tag     = bus.tag_out;
      held_ovf     = bus.ovf;

      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("out_valid_unexpected", bus.out_valid, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result", bus.result, e.result);
          check("tag_out", bus.tag_out, e.tag);
          check("ovf", bus.ovf, e.ovf);
        end
        n_drn++;
        drain_cyc.push_back(cyc);
      end
      if (bus.in_valid && bus.in_ready) begin
        if (golden_q.size() > 0) sb.push_back(golden_q.pop_front());
        else sb.push_back(model(bus.imm_in, bus.mode, bus.use_pc, bus.pc_in, bus.tag_in));
        n_acc++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [MAXW-1:0] imm, input logic [1:0] mode, input logic use_pc,
                       input logic [OUTW-1:0] pc, input logic [TAGW-1:0] tag);
    bus.in_valid = 1'b1;
    bus.imm_in   = imm;
    bus.mode     = mode;
    bus.use_pc   = use_pc;
    bus.pc_in    = pc;
    bus.tag_in   = tag;
  endtask

  task automatic drive_rand(input logic [TAGW-1:0] tag);
    drive(MAXW'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), OUTW'($urandom), tag);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick();
    check("drain_empty", sb.size(), 0);
  endtask

  function automatic exp_t gold(input logic [OUTW-1:0] res, input logic [TAGW-1:0] tag, input logic ovf);
    exp_t g;
    g.result = res;
    g.tag    = tag;
    g.ovf    = ovf;
    return g;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic wrap_ovf;
    int   b_acc;
    int   b_drn;
`ifdef BRANCH_TARGET_OVF_EN
    wrap_ovf = 1'b1;
`else
    wrap_ovf = 1'b0;
`endif
    bus.in_valid  = 1'b0;
    bus.imm_in    = '0;
    bus.mode      = '0;
    bus.use_pc    = 1'b0;
    bus.pc_in     = '0;
    bus.tag_in    = '0;
    bus.out_ready = 1'b1;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_tag_out", bus.tag_out, 0);
    check("rst_ovf", bus.ovf, 0);
    check("rst_in_ready", bus.in_ready, 1);
    tick();
    rst = 1'b0;
    tick();

    // Single request: latency and value
    golden_q.push_back(gold(16'h00FE, 4'hA, 1'b0));
    drive(12'hFFF, 2'b01, 1'b1, 16'h0100, 4'hA);
    @(negedge clk);
    check("lat_in_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("lat_after_accept", bus.out_valid, 0);
    tick();
    @(negedge clk);
    check("lat_presented", bus.out_valid, 1);
    check("lat_result", bus.result, 16'h00FE);
    tick();
    wait_drain(10);

    // Directed vectors with hand-derived results
    golden_q.push_back(gold(16'h10FE, 4'h1, 1'b0));
    golden_q.push_back(gold(16'hFF00, 4'h2, 1'b0));
    golden_q.push_back(gold(16'h0100, 4'h3, 1'b0));
    golden_q.push_back(gold(16'h0010, 4'h4, wrap_ovf));
    drive(12'h7FF, 2'b01, 1'b1, 16'h0100, 4'h1); tick();
    drive(12'hF80, 2'b00, 1'b0, 16'h1234, 4'h2); tick();
    drive(12'hF80, 2'b10, 1'b0, 16'h1234, 4'h3); tick();
    drive(12'h010, 2'b01, 1'b1, 16'hFFF0, 4'h4); tick();
    bus.in_valid = 1'b0;
    wait_drain(10);

    // Back-to-back stream, tags 0..7
    drain_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      drive_rand(TAGW'(i));
      @(negedge clk);
      check("stream_in_ready", bus.in_ready, 1);
      tick();
    end
    bus.in_valid = 1'b0;
    wait_drain(12);
    check("stream_count", drain_cyc.size(), 8);
    if (drain_cyc.size() == 8) check("stream_span", drain_cyc[7] - drain_cyc[0], 7);

    // Back-pressure: pipe fills after two accepts
    bus.out_ready = 1'b0;
    b_acc = n_acc;
    for (int i = 0; i < 6; i++) begin
      drive_rand(TAGW'(8 + i));
      tick();
    end
    check("stall_accepts", n_acc - b_acc, 2);
    @(negedge clk);
    check("stall_in_ready", bus.in_ready, 0);
    check("stall_out_valid", bus.out_valid, 1);
    tick();

    // One-cycle out_ready pulse: one drain and one accept together
    b_acc = n_acc;
    b_drn = n_drn;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("pulse_in_ready", bus.in_ready, 1);
    tick();
    bus.out_ready = 1'b0;
    check("pulse_drained", n_drn - b_drn, 1);
    check("pulse_accepted", n_acc - b_acc, 1);
    @(negedge clk);
    check("pulse_after_in_ready", bus.in_ready, 0);
    tick();

    // Reset with both stages full: entries discarded
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    sb.delete();
    @(negedge clk);
    check("rst_full_out_valid", bus.out_valid, 0);
    check("rst_full_result", bus.result, 0);
    check("rst_full_in_ready", bus.in_ready, 1);
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    b_drn = n_drn;
    repeat (4) tick();
    check("rst_full_no_emit", n_drn - b_drn, 0);

    // Random traffic with random back-pressure
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) != 0) drive_rand(TAGW'($urandom));
      else bus.in_valid = 1'b0;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
